cpc_busrq_arbiter: RTL and testbench

- Shares the CPC Z80 bus-request mechanism among the backplane expansion slots.
- Each slot raises a private request line. The arbiter drives the single open-drain BUSRQ_B to the CPC and waits for BUSACK_B.
- It grants exactly one slot at a time, round-robin, and releases the bus when the holder drops its request.
- Sits on the backplane, clocked from the CPC CLK line.

---
 rtl/cpc_busrq_arbiter_if.sv | 36 +++
 rtl/cpc_busrq_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cpc_busrq_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpc_busrq_arbiter_if.sv
// cpc_busrq_arbiter_if: backplane-side handshake bundle for the bus-request arbiter.
//   SLOT_REQ  per-slot bus request, active-high, synchronous to CLK
//   SLOT_GNT  one-hot grant, active-high
//   GNT_ID    binary index of the granted slot (0 when no grant)
//   BUSRQ_B   to the CPC, low requests the bus (board buffers it open-drain)
//   BUSACK_B  from the CPC, asynchronous, low when the Z80 has released the bus
//   TIMEOUT   one-cycle pulse when a grant is revoked (0 unless the timeout build is used)
// modport master: the arbiter. modport slave: the slots and CPC side.
interface cpc_busrq_arbiter_if #(
    parameter int unsigned NSLOTS = 4
);
    logic [NSLOTS-1:0] SLOT_REQ;
    logic [NSLOTS-1:0] SLOT_GNT;
    logic [2:0]        GNT_ID;
    logic              BUSRQ_B;
    logic              BUSACK_B;
    logic              TIMEOUT;

    modport master (
        input  SLOT_REQ,
        input  BUSACK_B,
        output SLOT_GNT,
        output GNT_ID,
        output BUSRQ_B,
        output TIMEOUT
    );

    modport slave (
        output SLOT_REQ,
        output BUSACK_B,
        input  SLOT_GNT,
        input  GNT_ID,
        input  BUSRQ_B,
        input  TIMEOUT
    );
endinterface

// File: rtl/cpc_busrq_arbiter.sv
// cpc_busrq_arbiter: shares the CPC Z80 BUSRQ/BUSACK mechanism among expansion slots.
// One slot holds the bus at a time, chosen round-robin; the bus is handed back to the
// Z80 when the holder drops its request.
// Ports:
//   CLK    CPC bus clock, all state on the rising edge
//   RESET  synchronous, active-high
//   bus    cpc_busrq_arbiter_if.master (SLOT_REQ, SLOT_GNT, GNT_ID, BUSRQ_B, BUSACK_B, TIMEOUT)
// Optional feature macro CPC_BUSRQ_TIMEOUT_EN: revoke a grant held for TIMEOUT_CYCLES
// cycles, pulse TIMEOUT, and lock that slot out until it drops its request once.
module cpc_busrq_arbiter #(
    parameter int unsigned NSLOTS         = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                 CLK,
    input logic                 RESET,
    cpc_busrq_arbiter_if.master bus
);
    localparam int unsigned IdxW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StGrant   = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   ack;
    logic                   ready_q, ready_d;
    logic [2:0]             last_q, last_d;
    logic [NSLOTS-1:0]      gnt_q, gnt_d;
    logic [2:0]             id_q, id_d;
    logic [NSLOTS-1:0]      elig;
    logic                   holder_req;
    logic                   win_found;
    logic [2:0]             win_id;
    int                     idx;

`ifdef CPC_BUSRQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NSLOTS-1:0] lock_q, lock_d;
    logic              tmo_q, tmo_d;
    assign elig = bus.SLOT_REQ & ~lock_q;
`else
    assign elig = bus.SLOT_REQ;
`endif

    // BUSACK_B synchroniser. sync_vld_q marks when every stage holds a real pin sample,
    // so the reset value of the flops cannot be mistaken for the Z80 having let go.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q     <= '1;
            sync_vld_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.BUSACK_B};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ack        = ~sync_q[SYNC_STAGES-1];
    assign holder_req = |(gnt_q & bus.SLOT_REQ);

    // Round-robin: first eligible slot after last_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 1; k <= int'(NSLOTS); k++) begin
            idx = int'(last_q) + k;
            if (idx >= int'(NSLOTS)) idx = idx - int'(NSLOTS);
            if (!win_found && elig[idx[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        ready_d = ready_q | (sync_vld_q[SYNC_STAGES-1] & ~ack);
`ifdef CPC_BUSRQ_TIMEOUT_EN
        cnt_d  = cnt_q;
        lock_d = lock_q & bus.SLOT_REQ;
        tmo_d  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (ready_q && (|elig)) state_d = StReq;
            end
            StReq: begin
                if (!(|elig)) begin
                    state_d = StRelease;
                end else if (ack && win_found) begin
                    gnt_d   = NSLOTS'(1) << win_id;
                    id_d    = win_id;
                    last_d  = win_id;
                    state_d = StGrant;
`ifdef CPC_BUSRQ_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            StGrant: begin
                // A lost ACK is a protocol violation; treat it like a release.
                if (!ack || !holder_req) begin
                    gnt_d   = '0;
                    id_d    = '0;
                    state_d = StRelease;
                end else begin
`ifdef CPC_BUSRQ_TIMEOUT_EN
                    if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        lock_d  = lock_d | gnt_q;
                        tmo_d   = 1'b1;
                        gnt_d   = '0;
                        id_d    = '0;
                        state_d = StRelease;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                // Hold BUSRQ_B high until the Z80 has reclaimed the bus.
                if (!ack) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= 3'(NSLOTS - 1);
            ready_q <= 1'b0;
`ifdef CPC_BUSRQ_TIMEOUT_EN
            cnt_q  <= '0;
            lock_q <= '0;
            tmo_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            ready_q <= ready_d;
`ifdef CPC_BUSRQ_TIMEOUT_EN
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            tmo_q  <= tmo_d;
`endif
        end
    end

    assign bus.SLOT_GNT = gnt_q;
    assign bus.GNT_ID   = id_q;
    // RESET forces the request off at once, without waiting for the clock edge.
    assign bus.BUSRQ_B  = RESET | ~((state_q == StReq) | (state_q == StGrant));
`ifdef CPC_BUSRQ_TIMEOUT_EN
    assign bus.TIMEOUT = tmo_q;
`else
    assign bus.TIMEOUT = 1'b0;
`endif
endmodule

// File: tb/tb_cpc_busrq_arbiter.sv
module tb_cpc_busrq_arbiter;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TC = 16;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    cpc_busrq_arbiter_if #(.NSLOTS(N)) bus ();

    cpc_busrq_arbiter #(
        .NSLOTS        (N),
        .SYNC_STAGES   (S),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // ---------------- CPC/Z80 responder ----------------
    bit z80_force = 1;
    bit z80_val   = 1;
    int lo_cnt = 0, hi_cnt = 0, dly = 0;

    initial begin
        bus.BUSACK_B = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            if (z80_force) begin
                bus.BUSACK_B = z80_val;
            end else if (!bus.BUSRQ_B) begin
                hi_cnt = 0;
                if (lo_cnt == 0) dly = $urandom_range(0, 4);
                if (lo_cnt >= dly) bus.BUSACK_B = 1'b0;
                else lo_cnt++;
            end else begin
                lo_cnt = 0;
                if (hi_cnt == 0) dly = $urandom_range(0, 4);
                if (hi_cnt >= dly) bus.BUSACK_B = 1'b1;
                else hi_cnt++;
            end
        end
    end

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_REQ, M_GRANT, M_REL} mph_t;
    mph_t       m_ph     = M_IDLE;
    int         m_last   = N - 1;
    int         m_holder = -1;
    bit         m_hist[$];      // pin samples, newest first
    bit         m_ready  = 0;
    int         m_edges  = 0;
    int         m_cnt    = 0;
    bit [N-1:0] m_lock   = '0;
    bit         m_tmo    = 0;

    always @(posedge CLK) begin
        bit         a;
        bit         ready_old;
        bit [N-1:0] req, elig, new_lock;
        req = bus.SLOT_REQ;
        if (RESET) begin
            m_ph = M_IDLE; m_last = N - 1; m_holder = -1; m_ready = 0;
            m_edges = 0; m_cnt = 0; m_lock = '0; m_tmo = 0;
            m_hist = {};
            repeat (S) m_hist.push_back(1'b1);
        end else begin
            a = (m_hist[S-1] == 1'b0);
            m_hist.push_front(bus.BUSACK_B);
            void'(m_hist.pop_back());
            ready_old = m_ready;
            if (m_edges >= S && !a) m_ready = 1;
            m_edges++;
            m_tmo = 0;
            elig = req;
            new_lock = '0;
`ifdef CPC_BUSRQ_TIMEOUT_EN
            elig = req & ~m_lock;
            new_lock = m_lock & req;
`endif
            case (m_ph)
                M_IDLE: if (ready_old && elig != 0) m_ph = M_REQ;
                M_REQ: begin
                    if (elig == 0) m_ph = M_REL;
                    else if (a) begin
                        for (int k = 1; k <= N; k++) begin
                            if (elig[(m_last + k) % N]) begin
                                m_holder = (m_last + k) % N;
                                break;
                            end
                        end
                        m_last = m_holder;
                        m_cnt = 0;
                        m_ph = M_GRANT;
                    end
                end
                M_GRANT: begin
                    if (!a || !req[m_holder]) begin
                        m_holder = -1;
                        m_ph = M_REL;
                    end else begin
`ifdef CPC_BUSRQ_TIMEOUT_EN
                        if (m_cnt == TC - 1) begin
                            new_lock[m_holder] = 1'b1;
                            m_tmo = 1;
                            m_holder = -1;
                            m_ph = M_REL;
                        end else m_cnt++;
`endif
                    end
                end
                M_REL: if (!a) m_ph = M_IDLE;
            endcase
            m_lock = new_lock;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_gnt", int'(bus.SLOT_GNT), (m_holder >= 0) ? (1 << m_holder) : 0);
            check("model_id", int'(bus.GNT_ID), (m_holder >= 0) ? m_holder : 0);
            check("model_busrq", int'(bus.BUSRQ_B),
                  (RESET || !(m_ph == M_REQ || m_ph == M_GRANT)) ? 1 : 0);
            check("model_timeout", int'(bus.TIMEOUT), int'(m_tmo));
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n, g, t;
        bus.SLOT_REQ = '0;
        RESET = 1'b1;
        step(1);
        chk_en = 1;
        step(2);
        // reset state
        check("rst_gnt", int'(bus.SLOT_GNT), 0);
        check("rst_id", int'(bus.GNT_ID), 0);
        check("rst_busrq", int'(bus.BUSRQ_B), 1);
        check("rst_timeout", int'(bus.TIMEOUT), 0);
        RESET = 1'b0;
        step(S + 3);

        // single request with a hand-timed acknowledge
        bus.SLOT_REQ = 4'b0001;
        n = 0;
        while (bus.BUSRQ_B && n < 20) begin step(1); n++; end
        check("req_to_busrq", n, 1);
        step(3);
        z80_val = 0;
        n = 0;
        while (bus.SLOT_GNT == 0 && n < 20) begin step(1); n++; end
        check("ack_to_gnt", n, 3);
        check("single_gnt", int'(bus.SLOT_GNT), 1);
        check("single_id", int'(bus.GNT_ID), 0);
        bus.SLOT_REQ = 4'b0000;
        step(1);
        check("drop_gnt", int'(bus.SLOT_GNT), 0);
        check("drop_busrq", int'(bus.BUSRQ_B), 1);
        z80_val = 1;
        step(S + 3);

        // round-robin with all slots requesting, from a fresh reset
        z80_force = 0;
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        step(S + 3);
        bus.SLOT_REQ = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            n = 0;
            while (bus.SLOT_GNT == 0 && n < 60) begin step(1); n++; end
            check("rr_gnt", int'(bus.SLOT_GNT), 1 << (r % 4));
            check("rr_id", int'(bus.GNT_ID), r % 4);
            step(10);
            bus.SLOT_REQ[r % 4] = 1'b0;
            step(1);
            bus.SLOT_REQ[r % 4] = 1'b1;
        end
        bus.SLOT_REQ = '0;
        step(15);

        // abandoned request: never granted, round-robin pointer untouched
        z80_force = 1;
        z80_val = 1;
        step(10);
        bus.SLOT_REQ = 4'b0100;
        g = 0;
        step(3);
        check("abandon_busrq_low", int'(bus.BUSRQ_B), 0);
        bus.SLOT_REQ = 4'b0000;
        step(1);
        check("abandon_busrq_high", int'(bus.BUSRQ_B), 1);
        for (int i = 0; i < 8; i++) begin
            if (bus.SLOT_GNT != 0) g++;
            step(1);
        end
        check("abandon_nognt", g, 0);
        z80_force = 0;
        bus.SLOT_REQ = 4'b1010;
        n = 0;
        while (bus.SLOT_GNT == 0 && n < 60) begin step(1); n++; end
        check("abandon_next_id", int'(bus.GNT_ID), 1);
        bus.SLOT_REQ = '0;
        step(15);

        // reset while granted, Z80 still holding the bus
        bus.SLOT_REQ = 4'b0001;
        n = 0;
        while (bus.SLOT_GNT == 0 && n < 60) begin step(1); n++; end
        check("rg_gnt", int'(bus.SLOT_GNT), 1);
        z80_force = 1;
        z80_val = 0;
        RESET = 1'b1;
        step(1);
        check("rg_busrq", int'(bus.BUSRQ_B), 1);
        check("rg_gnt_clr", int'(bus.SLOT_GNT), 0);
        RESET = 1'b0;
        g = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (!bus.BUSRQ_B) g++;
        end
        check("rg_no_busrq", g, 0);
        z80_val = 1;
        n = 0;
        while (bus.BUSRQ_B && n < 20) begin step(1); n++; end
        check("rg_busrq_after", int'(bus.BUSRQ_B), 0);

        // protocol violation: ACK lost while granted
        z80_force = 0;
        n = 0;
        while (bus.SLOT_GNT == 0 && n < 60) begin step(1); n++; end
        check("pv_gnt", int'(bus.SLOT_GNT), 1);
        z80_force = 1;
        z80_val = 1;
        n = 0;
        while (bus.SLOT_GNT != 0 && n < 20) begin step(1); n++; end
        check("pv_latency", n, 3);
        check("pv_busrq", int'(bus.BUSRQ_B), 1);
        bus.SLOT_REQ = '0;
        step(8);
        z80_force = 0;

`ifdef CPC_BUSRQ_TIMEOUT_EN
        bus.SLOT_REQ = 4'b0100;
        n = 0;
        while (bus.SLOT_GNT == 0 && n < 60) begin step(1); n++; end
        n = 0;
        t = 0;
        while (bus.SLOT_GNT != 0 && n < 40) begin
            step(1);
            n++;
            if (bus.TIMEOUT) t++;
        end
        check("to_hold", n, TC);
        check("to_pulse", t, 1);
        bus.SLOT_REQ = 4'b0110;
        n = 0;
        while (bus.SLOT_GNT == 0 && n < 60) begin step(1); n++; end
        check("to_next_id", int'(bus.GNT_ID), 1);
        bus.SLOT_REQ = 4'b0100;
        g = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (bus.SLOT_GNT != 0) g++;
        end
        check("to_locked", g, 0);
        bus.SLOT_REQ = 4'b0000;
        step(1);
        bus.SLOT_REQ = 4'b0100;
        n = 0;
        while (bus.SLOT_GNT == 0 && n < 60) begin step(1); n++; end
        check("to_relock_id", int'(bus.GNT_ID), 2);
        check("to_relock_gnt", int'(bus.SLOT_GNT), 4);
`else
        bus.SLOT_REQ = 4'b0100;
        n = 0;
        while (bus.SLOT_GNT == 0 && n < 60) begin step(1); n++; end
        g = 0;
        t = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.SLOT_GNT != 4'b0100) g++;
            if (bus.TIMEOUT) t++;
        end
        check("hold_gnt", g, 0);
        check("hold_notimeout", t, 0);
`endif
        bus.SLOT_REQ = '0;
        step(15);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) bus.SLOT_REQ[b] = ~bus.SLOT_REQ[b];
            end
            RESET = ($urandom_range(0, 399) == 0);
            step(1);
        end
        RESET = 1'b0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
